// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the queued ALU control decoder: encodings, ALUOp values, entry layout.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_LDST  = 2'b00,
    ALUOP_LUI   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } aluop_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Stored tag width; the queue's TAG_W parameter must match it.
  localparam int ENTRY_TAG_W = 6;

  typedef struct packed {
    logic [3:0]             alu_ctrl;
    logic                   mem_size;
    logic                   illegal;
    logic [ENTRY_TAG_W-1:0] tag;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{alu_ctrl: ALU_NONE, mem_size: 1'b0, illegal: 1'b0, tag: '0};

endpackage

// File: rtl/alu_ctrl_decode.sv
// Per-lane combinational decode of ALUOp/funct3/funct7 into a queue entry.
// Define ALUCTL_EXT_OPS_EN to decode AND/OR/SLL/SRL/SRA extensions.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0]             i_alu_op,
  input  logic [2:0]             i_funct3,
  input  logic [6:0]             i_funct7,
  input  logic [ENTRY_TAG_W-1:0] i_tag,
  output entry_t                 o_entry
);

  // R/I-type legality follows from whether any encoding was selected.
  always_comb begin
    o_entry     = ENTRY_RESET;
    o_entry.tag = i_tag;
    case (i_alu_op)
      ALUOP_LDST: begin
        o_entry.alu_ctrl = ALU_ADD;
        o_entry.mem_size = (i_funct3 == 3'b010);
      end
      ALUOP_RTYPE: begin
        case (i_funct3)
          3'b000: begin
            if (i_funct7 == F7_BASE)     o_entry.alu_ctrl = ALU_ADD;
            else if (i_funct7 == F7_ALT) o_entry.alu_ctrl = ALU_SUB;
          end
          3'b100: o_entry.alu_ctrl = ALU_XOR;
`ifdef ALUCTL_EXT_OPS_EN
          3'b111: o_entry.alu_ctrl = ALU_AND;
          3'b110: o_entry.alu_ctrl = ALU_OR;
          3'b001: if (i_funct7 == F7_BASE) o_entry.alu_ctrl = ALU_SLL;
          3'b101: begin
            if (i_funct7 == F7_BASE)     o_entry.alu_ctrl = ALU_SRL;
            else if (i_funct7 == F7_ALT) o_entry.alu_ctrl = ALU_SRA;
          end
`endif
          default: ;
        endcase
        o_entry.illegal = (o_entry.alu_ctrl == ALU_NONE);
      end
      ALUOP_ITYPE: begin
        case (i_funct3)
          3'b000: o_entry.alu_ctrl = ALU_ADD;
          3'b110: o_entry.alu_ctrl = ALU_OR;
          3'b100: o_entry.alu_ctrl = ALU_XOR;
`ifdef ALUCTL_EXT_OPS_EN
          3'b111: o_entry.alu_ctrl = ALU_AND;
          3'b001: o_entry.alu_ctrl = ALU_SLL;
          3'b101: begin
            if (i_funct7 == F7_BASE)     o_entry.alu_ctrl = ALU_SRL;
            else if (i_funct7 == F7_ALT) o_entry.alu_ctrl = ALU_SRA;
          end
`else
          3'b101: o_entry.alu_ctrl = ALU_SRA;
`endif
          default: ;
        endcase
        o_entry.illegal = (o_entry.alu_ctrl == ALU_NONE);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_queue.sv
// Multi-lane decode queue: compacts valid lanes into a circular buffer, issues one entry per cycle.
// Decode extensions are enabled by defining ALUCTL_EXT_OPS_EN.
module alu_ctrl_queue
  import alu_ctrl_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int TAG_W = ENTRY_TAG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [LANES-1:0]   in_valid,
  output logic               in_ready,
  input  logic [2*LANES-1:0] in_alu_op,
  input  logic [3*LANES-1:0] in_funct3,
  input  logic [7*LANES-1:0] in_funct7,
  input  logic [TAG_W*LANES-1:0] in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_alu_ctrl,
  output logic               out_mem_size,
  output logic               out_illegal,
  output logic [TAG_W-1:0]   out_tag,
  output logic [7:0]         err_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - LANES);

  if (TAG_W != ENTRY_TAG_W) begin : g_tag_w_check
    $error("alu_ctrl_queue: TAG_W must equal alu_ctrl_pkg::ENTRY_TAG_W");
  end

  entry_t           w_lane [LANES];
  entry_t           r_mem  [DEPTH];
  entry_t           w_head;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_errCount;
  logic [PTR_W-1:0] w_wrIdx [LANES];
  logic [CNT_W-1:0] w_enqN;
  logic [CNT_W-1:0] w_illN;
  logic [8:0]       w_errSum;
  logic             w_enq;
  logic             w_deq;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    alu_ctrl_decode u_decode (
      .i_alu_op (in_alu_op[2*g +: 2]),
      .i_funct3 (in_funct3[3*g +: 3]),
      .i_funct7 (in_funct7[7*g +: 7]),
      .i_tag    (in_tag[TAG_W*g +: TAG_W]),
      .o_entry  (w_lane[g])
    );
  end

  // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
  always_comb begin
    w_enqN = '0;
    w_illN = '0;
    for (int i = 0; i < LANES; i++) begin
      w_wrIdx[i] = r_wrPtr + PTR_W'(w_enqN);
      if (in_valid[i]) begin
        w_enqN = w_enqN + CNT_W'(1);
        if (w_lane[i].illegal) w_illN = w_illN + CNT_W'(1);
      end
    end
  end

  assign in_ready  = (r_count <= READY_MAX);
  assign out_valid = (r_count != '0);
  assign w_enq     = in_ready & (|in_valid) & ~flush;
  assign w_deq     = out_valid & out_ready & ~flush;
  assign w_errSum  = {1'b0, r_errCount} + 9'(w_illN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
      r_errCount <= '0;
    end else if (flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_wrPtr    <= r_wrPtr + PTR_W'(w_enqN);
        r_errCount <= (w_errSum > 9'd255) ? 8'd255 : w_errSum[7:0];
      end
      if (w_deq) r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count <= r_count + (w_enq ? w_enqN : '0) - CNT_W'(w_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_enq) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_valid[i]) r_mem[w_wrIdx[i]] <= w_lane[i];
      end
    end
  end

  assign w_head       = out_valid ? r_mem[r_rdPtr] : ENTRY_RESET;
  assign out_alu_ctrl = w_head.alu_ctrl;
  assign out_mem_size = w_head.mem_size;
  assign out_illegal  = w_head.illegal;
  assign out_tag      = w_head.tag;
  assign err_count    = r_errCount;

endmodule

// File: tb/tb_alu_ctrl_queue.sv
// Self-checking bench for alu_ctrl_queue: directed scenarios plus randomized traffic vs a queue model.
module tb_alu_ctrl_queue;

  localparam int LANES = 2;
  localparam int DEPTH = 8;
  localparam int TAG_W = 6;
`ifdef ALUCTL_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_op;
  logic [5:0]  in_funct3;
  logic [13:0] in_funct7;
  logic [11:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_ctrl;
  logic        out_mem_size;
  logic        out_illegal;
  logic [5:0]  out_tag;
  logic [7:0]  err_count;

  int nChecks = 0;
  int nErrors = 0;
  bit chkEn   = 1'b0;

  typedef struct packed {
    logic [3:0] c;
    logic       m;
    logic       ill;
    logic [5:0] tag;
  } mEnt_t;

  mEnt_t      mq[$];
  mEnt_t      mEnt;
  mEnt_t      hExp;
  int         merr = 0;
  int         mSz;
  bit         mRdy;
  logic [3:0] mC;
  logic       mM;
  logic       mIll;

  alu_ctrl_queue #(.LANES(LANES), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_alu_op    (in_alu_op),
    .in_funct3    (in_funct3),
    .in_funct7    (in_funct7),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_ctrl (out_alu_ctrl),
    .out_mem_size (out_mem_size),
    .out_illegal  (out_illegal),
    .out_tag      (out_tag),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode straight from the encoding table.
  function automatic void refDecode(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                    output logic [3:0] c, output logic m, output logic ill);
    c = 4'b1111; m = 1'b0; ill = 1'b0;
    if (op == 2'b00) begin
      c = 4'b0010;
      m = (f3 == 3'b010);
    end else if (op == 2'b10) begin
      if (f3 == 3'b000 && f7 == 7'h00) c = 4'b0010;
      else if (f3 == 3'b000 && f7 == 7'h20) c = 4'b0110;
      else if (f3 == 3'b100) c = 4'b0011;
      else if (EXT && f3 == 3'b111) c = 4'b0000;
      else if (EXT && f3 == 3'b110) c = 4'b0001;
      else if (EXT && f3 == 3'b001 && f7 == 7'h00) c = 4'b0100;
      else if (EXT && f3 == 3'b101 && f7 == 7'h00) c = 4'b0101;
      else if (EXT && f3 == 3'b101 && f7 == 7'h20) c = 4'b0111;
      ill = (c == 4'b1111);
    end else if (op == 2'b11) begin
      if (f3 == 3'b000) c = 4'b0010;
      else if (f3 == 3'b110) c = 4'b0001;
      else if (f3 == 3'b100) c = 4'b0011;
      else if (!EXT && f3 == 3'b101) c = 4'b0111;
      else if (EXT && f3 == 3'b111) c = 4'b0000;
      else if (EXT && f3 == 3'b001) c = 4'b0100;
      else if (EXT && f3 == 3'b101 && f7 == 7'h00) c = 4'b0101;
      else if (EXT && f3 == 3'b101 && f7 == 7'h20) c = 4'b0111;
      ill = (c == 4'b1111);
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setLane(input int l, input logic [1:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [5:0] tag);
    in_alu_op[2*l +: 2] = op;
    in_funct3[3*l +: 3] = f3;
    in_funct7[7*l +: 7] = f7;
    in_tag[6*l +: 6]    = tag;
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic oRdy, input logic fl);
    in_valid  = v;
    out_ready = oRdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Model: a FIFO of decoded entries plus an error counter, advanced at each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      merr = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      mSz  = mq.size();
      mRdy = (DEPTH - mSz) >= LANES;
      if (mSz > 0 && out_ready) void'(mq.pop_front());
      if (mRdy && in_valid != 2'b00) begin
        for (int i = 0; i < LANES; i++) begin
          if (in_valid[i]) begin
            refDecode(in_alu_op[2*i +: 2], in_funct3[3*i +: 3], in_funct7[7*i +: 7], mC, mM, mIll);
            mEnt = '{c: mC, m: mM, ill: mIll, tag: in_tag[6*i +: 6]};
            mq.push_back(mEnt);
            if (mIll) merr = (merr >= 255) ? 255 : merr + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      hExp = (mq.size() > 0) ? mq[0] : '{c: 4'b1111, m: 1'b0, ill: 1'b0, tag: 6'd0};
      checkOutput("in_ready",     32'(in_ready),     32'((DEPTH - mq.size()) >= LANES));
      checkOutput("out_valid",    32'(out_valid),    32'(mq.size() > 0));
      checkOutput("out_alu_ctrl", 32'(out_alu_ctrl), 32'(hExp.c));
      checkOutput("out_mem_size", 32'(out_mem_size), 32'(hExp.m));
      checkOutput("out_illegal",  32'(out_illegal),  32'(hExp.ill));
      checkOutput("out_tag",      32'(out_tag),      32'(hExp.tag));
      checkOutput("err_count",    32'(err_count),    32'(merr));
    end
  end

  int drainTags [8];

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 2'b00; out_ready = 1'b0;
    in_alu_op = '0; in_funct3 = '0; in_funct7 = '0; in_tag = '0;

    applyStimulus(2'b00, 1'b0, 1'b0);
    chkEn = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst alu_ctrl",  32'(out_alu_ctrl), 32'hF);
    checkOutput("rst tag",       32'(out_tag), 32'd0);
    checkOutput("rst err_count", 32'(err_count), 32'd0);

    // Two-lane bundle: SUB tag 3 then word load tag 4.
    setLane(0, 2'b10, 3'b000, 7'h20, 6'd3);
    setLane(1, 2'b00, 3'b010, 7'h00, 6'd4);
    applyStimulus(2'b11, 1'b1, 1'b0);
    checkOutput("pair0 valid", 32'(out_valid), 32'd1);
    checkOutput("pair0 alu",   32'(out_alu_ctrl), 32'b0110);
    checkOutput("pair0 tag",   32'(out_tag), 32'd3);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("pair1 alu",   32'(out_alu_ctrl), 32'b0010);
    checkOutput("pair1 mem",   32'(out_mem_size), 32'd1);
    checkOutput("pair1 tag",   32'(out_tag), 32'd4);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("pair empty",  32'(out_valid), 32'd0);

    // Sparse lane: only lane 1 (I-type OR) enters.
    setLane(0, 2'b10, 3'b111, 7'h00, 6'd8);
    setLane(1, 2'b11, 3'b110, 7'h00, 6'd9);
    applyStimulus(2'b10, 1'b0, 1'b0);
    checkOutput("sparse alu", 32'(out_alu_ctrl), 32'b0001);
    checkOutput("sparse tag", 32'(out_tag), 32'd9);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("sparse count1", 32'(out_valid), 32'd0);

    // Fill to full with the consumer stalled, then drain across the wrap.
    for (int k = 0; k < 3; k++) begin
      setLane(0, 2'b00, 3'b010, 7'h00, 6'(10 + 2*k));
      setLane(1, 2'b00, 3'b010, 7'h00, 6'(11 + 2*k));
      applyStimulus(2'b11, 1'b0, 1'b0);
    end
    checkOutput("fill6 in_ready", 32'(in_ready), 32'd1);
    setLane(0, 2'b00, 3'b000, 7'h00, 6'd16);
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("fill7 in_ready", 32'(in_ready), 32'd0);
    setLane(0, 2'b00, 3'b000, 7'h00, 6'd30);
    setLane(1, 2'b00, 3'b000, 7'h00, 6'd31);
    applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("blocked in_ready", 32'(in_ready), 32'd0);
    checkOutput("blocked head",     32'(out_tag), 32'd10);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("pop6 in_ready", 32'(in_ready), 32'd1);
    setLane(0, 2'b00, 3'b000, 7'h00, 6'd17);
    setLane(1, 2'b00, 3'b000, 7'h00, 6'd18);
    applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("fill8 in_ready", 32'(in_ready), 32'd0);
    drainTags = '{11, 12, 13, 14, 15, 16, 17, 18};
    for (int k = 0; k < 8; k++) begin
      checkOutput("drain tag", 32'(out_tag), 32'(drainTags[k]));
      applyStimulus(2'b00, 1'b1, 1'b0);
    end
    checkOutput("drain empty", 32'(out_valid), 32'd0);

    // R-type funct3 111 in both lanes, then enough bundles to saturate err_count.
    setLane(0, 2'b10, 3'b111, 7'h00, 6'd40);
    setLane(1, 2'b10, 3'b111, 7'h00, 6'd41);
    applyStimulus(2'b11, 1'b1, 1'b0);
    checkOutput("and illegal", 32'(out_illegal), EXT ? 32'd0 : 32'd1);
    checkOutput("and alu",     32'(out_alu_ctrl), EXT ? 32'b0000 : 32'hF);
    checkOutput("and err",     32'(err_count), EXT ? 32'd0 : 32'd2);
    for (int k = 0; k < 300; k++) applyStimulus(2'b11, 1'b1, 1'b0);
    checkOutput("err saturate", 32'(err_count), EXT ? 32'd0 : 32'd255);
    for (int k = 0; k < 10; k++) applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("sat drained", 32'(out_valid), 32'd0);

    // Flush at count 5 colliding with enqueue and dequeue.
    setLane(0, 2'b00, 3'b000, 7'h00, 6'd50);
    setLane(1, 2'b11, 3'b000, 7'h00, 6'd51);
    applyStimulus(2'b11, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b0);
    applyStimulus(2'b01, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b1);
    checkOutput("flush valid", 32'(out_valid), 32'd0);
    checkOutput("flush ready", 32'(in_ready), 32'd1);
    checkOutput("flush alu",   32'(out_alu_ctrl), 32'hF);
    checkOutput("flush err",   32'(err_count), EXT ? 32'd0 : 32'd255);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("flush stays empty", 32'(out_valid), 32'd0);

    // Reset in the middle of traffic discards entries and clears err_count.
    applyStimulus(2'b11, 1'b0, 1'b0);
    rst_n = 1'b0;
    applyStimulus(2'b11, 1'b0, 1'b0);
    checkOutput("midrst valid", 32'(out_valid), 32'd0);
    checkOutput("midrst err",   32'(err_count), 32'd0);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int k = 0; k < 2500; k++) begin
      for (int l = 0; l < LANES; l++) begin
        logic [6:0] f7;
        case ($urandom_range(0, 2))
          0:       f7 = 7'h00;
          1:       f7 = 7'h20;
          default: f7 = 7'($urandom);
        endcase
        setLane(l, 2'($urandom), 3'($urandom), f7, 6'($urandom));
      end
      rst_n = ($urandom_range(0, 299) != 0);
      applyStimulus(2'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_queue.md
# alu_ctrl_queue

Multi-lane, queued successor to the single-instruction ALU control decoder. It accepts up to LANES decode bundles per cycle (ALUOp, funct3, funct7, tag) and decodes them at enqueue into ALU control, memory size and illegal-op fields. Decoded entries are stored in an in-order circular queue and issued one per cycle, under a valid/ready handshake, toward the reservation stations. It sits between the rename/decode stage and issue, and also keeps a saturating count of illegal encodings.

## Interface
- LANES, 2, enqueue lanes per cycle (1..4)
- DEPTH, 8, queue entries; power of two, ≥ LANES
- TAG_W, 6, width of the per-instruction ROB tag carried through
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  discard all queued entries (mispredict recovery)
- in_valid  in  LANES  per-lane bundle valid; may be sparse (e.g. 2'b10)
- in_ready  out  1  queue can take a full LANES-wide bundle this cycle
- in_alu_op  in  2*LANES  lane i at [2i+1:2i]
- in_funct3  in  3*LANES  per-lane funct3
- in_funct7  in  7*LANES  per-lane funct7
- in_tag  in  TAG_W*LANES  per-lane tag
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head
- out_alu_ctrl  out  4  decoded ALU control
- out_mem_size  out  1  1 = word, 0 = byte
- out_illegal  out  1  encoding not supported
- out_tag  out  TAG_W  tag of head entry
- err_count  out  8  saturating count of illegal entries enqueued

## Operation
- Encodings: ADD 0010, SUB 0110, XOR 0011, OR 0001, SRA 0111, AND 0000, SLL 0100, SRL 0101, none 1111.
- ALUOp 00 (load/store): ADD. mem_size = 1 when funct3 = 010, else 0. Never illegal.
- ALUOp 01 (LUI): 1111, not illegal.
- ALUOp 10 (R-type): funct3 000 with funct7 0000000 → ADD; funct3 000 with funct7 0100000 → SUB; funct3 100 → XOR. Any other combination → 1111, illegal.
- ALUOp 11 (I-type): funct3 000 → ADD, 110 → OR, 100 → XOR, 101 → SRA (funct7 ignored). Other funct3 → 1111, illegal.
- mem_size = 0 for every ALUOp other than 00.
- Enqueue fires when in_ready & |in_valid & !flush.
- Valid lanes are compacted in lane order, lane 0 first, and written at wr_ptr, wr_ptr+1, … modulo DEPTH. wr_ptr advances by popcount(in_valid).
- Dequeue fires when out_valid & out_ready & !flush. rd_ptr advances by 1 modulo DEPTH.
- count_next = count + enq_n − deq. Simultaneous enqueue and dequeue are both honoured.
- flush: count, rd_ptr and wr_ptr all go to 0. flush has priority over enqueue and dequeue in the same cycle. err_count is not cleared by flush.
- err_count increments by the number of illegal lanes accepted and saturates at 255.

## Timing
- Reset (rst_n low at an edge) sets: count 0, both pointers 0, err_count 0. Outputs after reset: out_valid 0, in_ready 1, out_alu_ctrl 1111, out_mem_size 0, out_illegal 0, out_tag 0.
- Reset asserted mid-operation discards all entries at that edge.
- in_ready = (DEPTH − count) ≥ LANES. It is computed from registered count only, so there is no combinational path from in_valid or out_ready. A same-cycle dequeue does not grant extra space.
- Latency: a bundle accepted at edge N into an empty queue shows lane 0 at the output after edge N, with out_valid high in cycle N+1.
- Output fields are read from queue storage at rd_ptr. They hold steady while out_valid & !out_ready.
- When count = 0, out_valid = 0 and output fields read as reset values (1111 / 0 / 0 / 0).

## Configuration
- ALUCTL_EXT_OPS_EN defined:
  - R-type: funct3 111 → AND; 110 → OR; 001 (funct7 0) → SLL; 101 with funct7 0000000 → SRL; 101 with funct7 0100000 → SRA.
  - I-type: 111 → AND; 001 → SLL; 101 with funct7 0000000 → SRL, 0100000 → SRA, other funct7 → illegal.
- Not defined: decode exactly as in Operation. The ops listed above produce 1111 and illegal, except I-type 101, which is SRA regardless of funct7.

## Structure
- Shared package alu_ctrl_pkg holds:
  - the 4-bit ALU control encoding constants
  - the ALUOp constants (LDST, LUI, RTYPE, ITYPE)
  - the decoded-entry struct (alu_ctrl, mem_size, illegal, tag).
- One combinational sub-module, alu_ctrl_decode, instantiated once per lane. The queue, compaction and counters live in alu_ctrl_queue.

## Test plan
- Reset, then idle → out_valid 0, in_ready 1, out_alu_ctrl 1111, err_count 0.
- LANES=2, in_valid 11 with {R-type 000 funct7 0100000, tag 3} and {load 010, tag 4}, out_ready 1 → cycle N+1: SUB 0110, tag 3; cycle N+2: ADD 0010, mem_size 1, tag 4.
- in_valid 10 with lane 1 = I-type 110 → single entry OR 0001, count 1.
- Fill to DEPTH=8 with out_ready 0 → in_ready 0 at count 7 and at count 8. Then drain 8 entries in order and refill across the wrap point; tags come out in order.
- R-type funct3 111 in both lanes → illegal 1 and err_count +2 without the macro; AND 0000 and illegal 0 with ALUCTL_EXT_OPS_EN. 130 such bundles → err_count saturates at 255.
- flush coincident with a valid enqueue and a dequeue at count 5 → next cycle count 0, out_valid 0, err_count unchanged.
